// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl
//
// Ramp sequencer for a single PWM channel. A command (target, step, divider)
// is accepted while idle; pwm_value then moves toward the target by one step
// every (div+1) rising edges of the PWM unit's period strobe. The target is
// clamped to pwm_range when the command is accepted.
//
// Ports:
//   pwm_clk     in   clock, rising edge
//   pwm_reset   in   asynchronous active-low reset
//   pwm_period  in   period strobe from the PWM unit (high while it is in reset)
//   pwm_range   in   current PWM range, sampled at command accept only
//   cmd_valid   in   command request
//   cmd_ready   out  high in IDLE
//   cmd_target  in   final duty value
//   cmd_step    in   increment per step (0 behaves as 1)
//   cmd_div     in   step every cmd_div+1 period edges
//   cmd_abort   in   stop an active ramp, keep the current value
//   pwm_value   out  duty value to the PWM unit
//   busy        out  ramp in progress
//   done        out  one-cycle pulse when the target is reached
//   state_dbg   out  current FSM state (0 IDLE, 1 RAMP_UP, 2 RAMP_DOWN)
//
// Handshake: a command transfers on a rising pwm_clk edge where
// cmd_valid & cmd_ready are both high. cmd_valid need not be held, and the
// command fields are only looked at in that cycle.

module pwm_fade_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 pwm_clk,
  input  logic                 pwm_reset,
  input  logic                 pwm_period,
  input  logic [WIDTH-1:0]     pwm_range,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_target,
  input  logic [WIDTH-1:0]     cmd_step,
  input  logic [DIV_WIDTH-1:0] cmd_div,
  input  logic                 cmd_abort,
  output logic [WIDTH-1:0]     pwm_value,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } state_t;

  state_t               state, state_d;
  logic                 period_q;
  logic [WIDTH-1:0]     tgt, tgt_d;
  logic [WIDTH-1:0]     stp, stp_d;
  logic [DIV_WIDTH-1:0] div, div_d;
  logic [DIV_WIDTH-1:0] div_cnt, div_cnt_d;
  logic [WIDTH-1:0]     value_d;
  logic                 done_d;

  logic                 edge_det;
  logic [WIDTH-1:0]     cmd_tgt_clamped;
  logic [WIDTH-1:0]     cmd_stp_fixed;
  logic [WIDTH-1:0]     dist_up;
  logic [WIDTH-1:0]     dist_down;

  // period_q resets high so a strobe held high through reset is not seen
  // as a rising edge once reset is released.
  assign edge_det        = pwm_period & ~period_q;
  assign cmd_tgt_clamped = (cmd_target > pwm_range) ? pwm_range : cmd_target;
  assign cmd_stp_fixed   = (cmd_step == '0) ? WIDTH'(1) : cmd_step;

  // Remaining distance; only meaningful in the matching ramp direction.
  // Comparing the distance against the step avoids any wrap of value+step.
  assign dist_up   = tgt - pwm_value;
  assign dist_down = pwm_value - tgt;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge pwm_clk or negedge pwm_reset) begin
    if (!pwm_reset) begin
      state     <= IDLE;
      period_q  <= 1'b1;
      tgt       <= '0;
      stp       <= '0;
      div       <= '0;
      div_cnt   <= '0;
      pwm_value <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      period_q  <= pwm_period;
      tgt       <= tgt_d;
      stp       <= stp_d;
      div       <= div_d;
      div_cnt   <= div_cnt_d;
      pwm_value <= value_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d   = state;
    tgt_d     = tgt;
    stp_d     = stp;
    div_d     = div;
    div_cnt_d = div_cnt;
    value_d   = pwm_value;
    done_d    = 1'b0;

    case (state)
      IDLE: begin
        // cmd_abort is ignored here; a coincident command is still taken.
        if (cmd_valid) begin
          tgt_d     = cmd_tgt_clamped;
          stp_d     = cmd_stp_fixed;
          div_d     = cmd_div;
          div_cnt_d = '0;
          if (cmd_tgt_clamped > pwm_value) begin
            state_d = RAMP_UP;
          end else if (cmd_tgt_clamped < pwm_value) begin
            state_d = RAMP_DOWN;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      RAMP_UP: begin
        // Abort takes priority over a step on the same edge.
        if (cmd_abort) begin
          state_d = IDLE;
        end else if (edge_det) begin
          if (div_cnt != div) begin
            div_cnt_d = div_cnt + DIV_WIDTH'(1);
          end else begin
            div_cnt_d = '0;
            if (dist_up <= stp) begin
              value_d = tgt;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              value_d = pwm_value + stp;
            end
          end
        end
      end

      RAMP_DOWN: begin
        if (cmd_abort) begin
          state_d = IDLE;
        end else if (edge_det) begin
          if (div_cnt != div) begin
            div_cnt_d = div_cnt + DIV_WIDTH'(1);
          end else begin
            div_cnt_d = '0;
            if (dist_down <= stp) begin
              value_d = tgt;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              value_d = pwm_value - stp;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
